shared_debounce_ctrl: RTL and testbench
=======================================

SHARED_DEBOUNCE_CTRL -- requirements
Module: shared_debounce_ctrl

Interface
REQ-001 SHALL have parameter COUNT, default 1: debounce interval in clk cycles (legal range 1 to 2^BITS-1).
REQ-002 SHALL have parameter BITS, default 1: width of the shared interval counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sig  input  4  raw switch/button levels, channel i = sig[i], already synchronised to clk.
REQ-006 SHALL have port db  output  4  debounced levels, one per channel.
REQ-007 SHALL have port evt_valid  output  1  debounced-change event available.
REQ-008 SHALL have port evt_id  output  2  channel index of the held event.
REQ-009 SHALL have port evt_level  output  1  new debounced level of the held event (1 = press, 0 = release).
REQ-010 SHALL have port evt_ready  input  1  consumer accepts the event when evt_valid and evt_ready are both high on a rising edge.
REQ-011 SHALL have port busy  output  1  high whenever the shared timer is allocated (state not IDLE).

Function
REQ-012 SHALL time-share one BITS-wide interval counter among all 4 channels; no per-channel counters.
REQ-013 SHALL define channel i as a candidate when sig[i] != db[i].
REQ-014 SHALL implement three states: IDLE, RUN, DONE.
REQ-015 IDLE: when at least one candidate exists and the event slot is free (evt_valid low, or evt_valid and evt_ready both high this cycle), SHALL latch grant = first candidate found searching ptr, ptr+1, ... mod 4, clear count to 0, and go to RUN; otherwise SHALL stay in IDLE.
REQ-016 RUN: count SHALL increment by 1 each cycle; when count == COUNT-1, SHALL go to DONE; count SHALL NOT wrap or run in any other state.
REQ-017 DONE: if sig[grant] != db[grant], SHALL toggle db[grant] and load the event slot (evt_valid=1, evt_id=grant, evt_level=new db[grant]); otherwise SHALL leave db and the event slot unchanged (bounce rejected).
REQ-018 DONE: SHALL set ptr = (grant+1) mod 4 regardless of outcome, and go to IDLE.
REQ-019 Latency: with the grant taken at rising edge k, db[grant] and evt_valid SHALL update at edge k+COUNT+1 (COUNT RUN cycles plus one DONE cycle).
REQ-020 A channel's input SHALL be sampled for acceptance only in DONE; glitches during RUN SHALL be ignored.
REQ-021 evt_valid SHALL clear on the accepting edge; evt_id and evt_level SHALL hold stable while evt_valid is high and not accepted.
REQ-022 Backpressure: while evt_valid is high and evt_ready is low, the controller SHALL NOT leave IDLE; new candidates wait with no loss of db state.
REQ-023 Simultaneous accept and grant in IDLE SHALL be permitted (zero-bubble restart).
REQ-024 Channels not granted SHALL keep db unchanged; at most one db bit SHALL change per DONE cycle.
REQ-025 A candidate that disappears before being granted SHALL simply not be granted; there SHALL be no pending memory per channel.
REQ-026 COUNT = 1 SHALL give exactly one RUN cycle.

Reset
REQ-027 On reset high at a rising edge, SHALL set state=IDLE, count=0, ptr=0, grant=0, db=4'b0000, evt_valid=0, evt_id=0, evt_level=0, busy=0.
REQ-028 Reset asserted mid-RUN or mid-DONE SHALL abort the check with no db change and no event.
REQ-029 Reset SHALL dominate evt_ready and all other inputs.

Verification
REQ-030 COUNT=4, evt_ready=1, sig=0001 held from edge k -> busy at k+1, db=0001, evt_valid=1, evt_id=0, evt_level=1 at k+5, single-cycle pulse.
REQ-031 COUNT=4, sig[2] pulses high for 2 cycles only -> after DONE db stays 0000, no event, ptr=3.
REQ-032 COUNT=4, sig=1111 from reset, evt_ready=1 -> db bits set in order 0,1,2,3, one per 6 cycles (IDLE+4 RUN+DONE), evt_id sequence 0,1,2,3.
REQ-033 evt_ready=0, sig 0000->0011 -> event for channel 0 held, busy low thereafter, db stays 0001; on evt_ready=1 the accept edge also grants channel 1, db=0011 5 edges later.
REQ-034 Reset asserted at RUN count=2 with sig=0100 -> db=0000, evt_valid=0, state IDLE; check restarts from count 0 after release.
REQ-035 ptr=3, candidates on channels 0 and 3 -> channel 3 granted first, then channel 0.

Source files
------------

// File: rtl/shared_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shared_debounce_ctrl
// Brief    : 4-channel switch debouncer sharing a single interval timer,
//            with a one-deep change-event slot and ready/valid handshake.
// Revision : 1.0 - initial release
// ============================================================================
module shared_debounce_ctrl #(
  parameter int COUNT = 1,
  parameter int BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sig,
  output logic [3:0] db,
  output logic       evt_valid,
  output logic [1:0] evt_id,
  output logic       evt_level,
  input  logic       evt_ready,
  output logic       busy
);

  localparam logic [BITS-1:0] c_last_cnt = BITS'(COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [BITS-1:0] r_count, w_count_nxt;
  logic [1:0]      r_ptr, w_ptr_nxt;
  logic [1:0]      r_grant, w_grant_nxt;
  logic [3:0]      r_db, w_db_nxt;
  logic            r_evt_valid, w_evt_valid_nxt;
  logic [1:0]      r_evt_id, w_evt_id_nxt;
  logic            r_evt_level, w_evt_level_nxt;

  logic [3:0]      w_cand;
  logic            w_found;
  logic [1:0]      w_pick;
  logic            w_slot_free;

  assign w_cand      = sig ^ r_db;
  assign w_slot_free = ~r_evt_valid | evt_ready;

  // Round-robin search from r_ptr; descending offsets so the nearest wins.
  always_comb begin
    logic [1:0] idx;
    w_found = 1'b0;
    w_pick  = r_ptr;
    idx     = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = r_ptr + 2'(i);
      if (w_cand[idx]) begin
        w_found = 1'b1;
        w_pick  = idx;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_ptr_nxt       = r_ptr;
    w_grant_nxt     = r_grant;
    w_db_nxt        = r_db;
    w_evt_valid_nxt = r_evt_valid & ~evt_ready;
    w_evt_id_nxt    = r_evt_id;
    w_evt_level_nxt = r_evt_level;
    case (r_state)
      ST_IDLE: begin
        if (w_found && w_slot_free) begin
          w_grant_nxt = w_pick;
          w_count_nxt = '0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_count_nxt = r_count + 1'b1;
        if (r_count == c_last_cnt) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // Input is only judged here; anything seen during RUN is ignored.
        if (sig[r_grant] != r_db[r_grant]) begin
          w_db_nxt[r_grant] = ~r_db[r_grant];
          w_evt_valid_nxt   = 1'b1;
          w_evt_id_nxt      = r_grant;
          w_evt_level_nxt   = ~r_db[r_grant];
        end
        w_ptr_nxt   = r_grant + 2'd1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_ptr       <= 2'd0;
      r_grant     <= 2'd0;
      r_db        <= 4'b0000;
      r_evt_valid <= 1'b0;
      r_evt_id    <= 2'd0;
      r_evt_level <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_ptr       <= w_ptr_nxt;
      r_grant     <= w_grant_nxt;
      r_db        <= w_db_nxt;
      r_evt_valid <= w_evt_valid_nxt;
      r_evt_id    <= w_evt_id_nxt;
      r_evt_level <= w_evt_level_nxt;
    end
  end

  assign db        = r_db;
  assign evt_valid = r_evt_valid;
  assign evt_id    = r_evt_id;
  assign evt_level = r_evt_level;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shared_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_debounce_ctrl
// Brief    : Self-checking bench: vector table, corner sequences, random run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shared_debounce_ctrl;

  localparam int COUNT = 4;
  localparam int BITS  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sig;
  logic [3:0] db;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_level;
  logic       evt_ready;
  logic       busy;

  int total = 0;
  int bad   = 0;

  shared_debounce_ctrl #(.COUNT(COUNT), .BITS(BITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .sig       (sig),
    .db        (db),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_level (evt_level),
    .evt_ready (evt_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: timer is just a deadline edge number, not a counter.
  int         cyc;
  logic [3:0] m_db;
  int         m_ptr;
  int         m_g;
  bit         m_busy;
  int         m_deadline;
  logic       m_v;
  logic [1:0] m_id;
  logic       m_lvl;

  task automatic model_edge(input logic [3:0] s, input logic r, input logic rst);
    logic [3:0] cand;
    bit         old_v;
    cyc++;
    if (rst) begin
      m_db = 4'b0; m_ptr = 0; m_g = 0; m_busy = 0;
      m_v = 1'b0; m_id = 2'd0; m_lvl = 1'b0;
    end else begin
      old_v = m_v;
      if (m_v && r) m_v = 1'b0;
      if (!m_busy) begin
        cand = s ^ m_db;
        if (cand != 4'b0 && (!old_v || r)) begin
          for (int off = 3; off >= 0; off--)
            if (cand[(m_ptr + off) % 4]) m_g = (m_ptr + off) % 4;
          m_busy     = 1;
          m_deadline = cyc + COUNT + 1;
        end
      end else if (cyc == m_deadline) begin
        if (s[m_g] != m_db[m_g]) begin
          m_db[m_g] = ~m_db[m_g];
          m_v   = 1'b1;
          m_id  = 2'(m_g);
          m_lvl = m_db[m_g];
        end
        m_ptr  = (m_g + 1) % 4;
        m_busy = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic [3:0] s, input logic r, input logic rst);
    sig = s; evt_ready = r; reset = rst;
    @(posedge clk);
    model_edge(s, r, rst);
    #1;
  endtask

  task automatic check_model();
    check("model_db",    8'(db),        8'(m_db));
    check("model_valid", 8'(evt_valid), 8'(m_v));
    check("model_busy",  8'(busy),      8'(m_busy));
    if (m_v) begin
      check("model_id",  8'(evt_id),    8'(m_id));
      check("model_lvl", 8'(evt_level), 8'(m_lvl));
    end
  endtask

  typedef struct {
    logic [3:0] s;
    logic       r;
    logic       rst;
    logic [3:0] e_db;
    logic       e_v;
    logic [1:0] e_id;
    logic       e_lvl;
    logic       e_busy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic [3:0] s, logic r, logic rst, logic [3:0] edb,
                              logic ev, logic [1:0] eid, logic elvl, logic eb);
    vec_t v;
    v.s = s; v.r = r; v.rst = rst; v.e_db = edb; v.e_v = ev;
    v.e_id = eid; v.e_lvl = elvl; v.e_busy = eb;
    return v;
  endfunction

  initial begin
    cyc = 0;
    sig = 4'b0; evt_ready = 1'b1; reset = 1'b1;

    // Press ch0, accept; ch2 glitch rejected; ptr=3 picks ch3 before ch0.
    vt.push_back(mk(4'b0000, 1, 1, 4'b0000, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) vt.push_back(mk(4'b0001, 1, 0, 4'b0000, 0, 0, 0, 1));
    vt.push_back(mk(4'b0001, 1, 0, 4'b0001, 1, 0, 1, 0));
    vt.push_back(mk(4'b0001, 1, 0, 4'b0001, 0, 0, 1, 0));
    vt.push_back(mk(4'b0101, 1, 0, 4'b0001, 0, 0, 1, 1));
    vt.push_back(mk(4'b0101, 1, 0, 4'b0001, 0, 0, 1, 1));
    for (int i = 0; i < 3; i++) vt.push_back(mk(4'b0001, 1, 0, 4'b0001, 0, 0, 1, 1));
    vt.push_back(mk(4'b0001, 1, 0, 4'b0001, 0, 0, 1, 0));
    for (int i = 0; i < 5; i++) vt.push_back(mk(4'b1000, 1, 0, 4'b0001, 0, 0, 1, 1));
    vt.push_back(mk(4'b1000, 1, 0, 4'b1001, 1, 3, 1, 0));
    for (int i = 0; i < 5; i++) vt.push_back(mk(4'b1000, 1, 0, 4'b1001, 0, 3, 1, 1));
    vt.push_back(mk(4'b1000, 1, 0, 4'b1000, 1, 0, 0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].s, vt[i].r, vt[i].rst);
      check("tbl_db",    8'(db),        8'(vt[i].e_db));
      check("tbl_valid", 8'(evt_valid), 8'(vt[i].e_v));
      check("tbl_busy",  8'(busy),      8'(vt[i].e_busy));
      if (vt[i].e_v) begin
        check("tbl_id",  8'(evt_id),    8'(vt[i].e_id));
        check("tbl_lvl", 8'(evt_level), 8'(vt[i].e_lvl));
      end
    end

    // Backpressure: ch0 event held, ch1 waits, accept edge grants ch1.
    step(4'b0000, 1, 1);
    for (int i = 0; i < 6; i++) begin step(4'b0011, 0, 0); check_model(); end
    check("bp_first_id", 8'(evt_id), 8'd0);
    for (int i = 0; i < 5; i++) begin
      step(4'b0011, 0, 0); check_model();
      check("bp_hold_busy", 8'(busy), 8'd0);
      check("bp_hold_db",   8'(db),   8'b0001);
      check("bp_hold_v",    8'(evt_valid), 8'd1);
    end
    step(4'b0011, 1, 0); check_model();
    check("bp_accept_v",    8'(evt_valid), 8'd0);
    check("bp_accept_busy", 8'(busy),      8'd1);
    for (int i = 0; i < 5; i++) begin step(4'b0011, 1, 0); check_model(); end
    check("bp_second_db", 8'(db), 8'b0011);
    check("bp_second_id", 8'(evt_id), 8'd1);

    // Reset in the middle of RUN aborts; check restarts from scratch.
    step(4'b0000, 1, 1);
    for (int i = 0; i < 3; i++) begin step(4'b0100, 1, 0); check_model(); end
    step(4'b0100, 1, 1);
    check("rst_mid_db",   8'(db),        8'd0);
    check("rst_mid_v",    8'(evt_valid), 8'd0);
    check("rst_mid_busy", 8'(busy),      8'd0);
    for (int i = 0; i < 5; i++) begin
      step(4'b0100, 1, 0); check_model();
      check("rst_rerun_db", 8'(db), 8'd0);
    end
    step(4'b0100, 1, 0); check_model();
    check("rst_rerun_done", 8'(db), 8'b0100);

    // All channels pressed: served in order 0..3, one per 6 edges.
    step(4'b0000, 1, 1);
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 6; i++) begin step(4'b1111, 1, 0); check_model(); end
      check("rr_id", 8'(evt_id), 8'(n));
      check("rr_db", 8'(db), 8'((1 << (n + 1)) - 1));
    end

    // Randomised run against the model.
    step(4'b0000, 1, 1);
    begin
      logic [3:0] rs;
      rs = 4'b0;
      for (int i = 0; i < 3000; i++) begin
        for (int b = 0; b < 4; b++)
          if ($urandom_range(7) == 0) rs[b] = ~rs[b];
        step(rs, ($urandom_range(3) != 0), ($urandom_range(299) == 0));
        check_model();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
